arp_tx_gmii: RTL and testbench
==============================

// Module: arp_tx_gmii
// PURPOSE
//  Builds and transmits one broadcast ARP request frame per trigger as a GMII byte stream
//  (gmii_tx_data/gmii_tx_en) in the gmii_tx_clk domain; output feeds the GMII->RGMII DDR stage.
//  Generates preamble/SFD, Ethernet header, ARP body, zero pad to 60 B, CRC-32 FCS, and inter-frame gap.
// PARAMETERS
//  SRC_MAC      48'h000A3501FEC0  sender MAC (Ethernet source and ARP SHA)
//  SRC_IP       32'hC0A80002      sender IP 192.168.0.2 (ARP SPA)
//  IFG_CYCLES   12                idle cycles after FCS before busy drops (minimum 12)
//  AUTO_PERIOD  125_000_000       cycles between auto triggers (used only with ARP_TX_AUTO_EN)
// PORTS
//  gmii_tx_clk   in   1   125 MHz transmit clock; sole clock
//  reset         in   1   asynchronous, active-high
//  start         in   1   single-cycle send request
//  dst_ip        in   32  target IP (ARP TPA); sampled when start is accepted
//  busy          out  1   high from start acceptance until end of IFG
//  done          out  1   one-cycle pulse on the cycle busy falls
//  gmii_tx_data  out  8   transmit byte, registered
//  gmii_tx_en    out  1   transmit enable, registered
// BEHAVIOUR
//  - Reset: state IDLE; gmii_tx_data=8'h00, gmii_tx_en=0, busy=0, done=0; CRC reg=32'hFFFFFFFF.
//    Reset mid-frame aborts immediately: tx_en drops asynchronously, and no done pulse is produced.
//  - Accept: start=1 in IDLE at edge N: dst_ip latched, busy=1 from N;
//    gmii_tx_en=1 with data 8'h55 after edge N+1.
//    start while busy is ignored (no queueing).
//  - FSM: IDLE -> PREAMBLE (7x 8'h55, then 8'hD5; 8 cycles)
//    -> BODY (60 bytes, byte counter 0..59) -> FCS (4 cycles)
//    -> IFG (IFG_CYCLES cycles, tx_en=0, data=0) -> IDLE.
//  - gmii_tx_en is high for exactly 72 contiguous cycles; there are no gaps inside a frame.
//  - BODY bytes (multi-byte fields MSB first):
//    0-5   FF x6 (broadcast)
//    6-11  SRC_MAC
//    12-13 08 06
//    14-15 00 01
//    16-17 08 00
//    18    06
//    19    04
//    20-21 00 01 (request)
//    22-27 SRC_MAC
//    28-31 SRC_IP
//    32-37 00 x6
//    38-41 dst_ip (latched)
//    42-59 00 pad
//  - CRC-32 (IEEE, reflected, poly 32'hEDB88320, init all-ones) is updated on every BODY byte.
//    It is cleared to all-ones in PREAMBLE and excludes the preamble and SFD.
//  - FCS = ~crc, sent low byte first (crc[7:0] first).
//  - done: on the last IFG cycle's edge, busy->0 and done=1 for exactly one cycle.
//    A start on that same cycle that done is high is accepted (back-to-back frames, gap = IFG_CYCLES).
//  - Counters: byte counter is 6 bits (0..59); the IFG counter is sized $clog2(IFG_CYCLES+1).
// CONFIGURATION
//  ARP_TX_AUTO_EN defined: an internal counter counts 0..AUTO_PERIOD-1 continuously from reset.
//    On wrap it issues an internal trigger, OR'd with start.
//    An internal trigger that arrives while busy is dropped; the counter keeps running.
//    On an auto trigger with no external start, dst_ip is still sampled as the target IP.
//  ARP_TX_AUTO_EN undefined: no counter logic; a frame is sent only on start.
// STRUCTURE
//  - Shared package/include eth_defs: ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, ETHERTYPE_ARP=16'h0806,
//    ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_OPER_REQ=16'h0001,
//    ETH_MIN_BODY=60, CRC32_POLY_REFL, CRC32_RESIDUE=32'hC704DD7B.
//  - State encoding localparams for IDLE/PREAMBLE/BODY/FCS/IFG are local to this module.
//  - Sub-module crc32_d8: combinational next-CRC from crc_in[31:0] and data[7:0].
//    This block holds the CRC register and its clear/enable control.
// TESTING
//  1. start at cycle 10, dst_ip=32'hC0A80003 -> tx_en rises at 11, 72 bytes captured,
//     first 8 = 55x7,D5; bytes 38-41 of the body = C0 A8 00 03; IFG of 12 low cycles, then done.
//  2. CRC check: CRC-32 over the 64 captured post-SFD bytes gives residue 32'hC704DD7B;
//     the 4 FCS bytes match a software model.
//  3. start pulsed during BODY and again during IFG -> no effect; exactly one frame, one done.
//  4. start on the done cycle -> second frame's tx_en rises 1 cycle later;
//     tx_en low gap between frames = 12 cycles.
//  5. reset asserted at body byte 30 -> tx_en=0, busy=0 asynchronously; no done;
//     the next start produces a complete, CRC-correct frame.
//  6. With ARP_TX_AUTO_EN and AUTO_PERIOD=200, start held low -> frames begin every 200 cycles;
//     without the macro -> no frames.

Source files
------------

// File: rtl/arp_tx_gmii_pkg.sv
// ---------------------------------------------------------------------------
// arp_tx_gmii_pkg
//   Shared Ethernet/ARP constants and the ARP body byte generator used by the
//   arp_tx_gmii transmitter and its CRC-32 helper.
//   No ports (package). Imported with: import arp_tx_gmii_pkg::*;
// ---------------------------------------------------------------------------
package arp_tx_gmii_pkg;

  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;

  localparam int ETH_PREAMBLE_LEN = 8;   // 7x preamble + SFD
  localparam int ETH_MIN_BODY     = 60;  // header + ARP + pad, FCS excluded
  localparam int ETH_FCS_LEN      = 4;
  localparam int ARP_HDR_BYTES    = 42;  // Ethernet header + ARP payload

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;

  // Byte idx (0..59) of the broadcast ARP request body. Bytes 42..59 are pad.
  // The 42 meaningful bytes are laid out MSB-first in one vector and the
  // wanted byte is shifted to the top, which keeps the field map readable.
  function automatic logic [7:0] arp_body_byte(input logic [5:0]  idx,
                                               input logic [47:0] mac,
                                               input logic [31:0] ip_src,
                                               input logic [31:0] ip_dst);
    logic [ARP_HDR_BYTES*8-1:0] hdr;
    logic [ARP_HDR_BYTES*8-1:0] sh;
    logic [7:0]                 b;
    hdr = {48'hFFFF_FFFF_FFFF,   // 0-5   broadcast destination
           mac,                  // 6-11  source MAC
           ETHERTYPE_ARP,        // 12-13
           ARP_HTYPE_ETH,        // 14-15
           ARP_PTYPE_IPV4,       // 16-17
           ARP_HLEN,             // 18
           ARP_PLEN,             // 19
           ARP_OPER_REQ,         // 20-21
           mac,                  // 22-27 SHA
           ip_src,               // 28-31 SPA
           48'h0,                // 32-37 THA (unknown)
           ip_dst};              // 38-41 TPA
    sh = hdr << {idx, 3'b000};
    b  = 8'h00;
    if (idx < 6'(ARP_HDR_BYTES)) b = sh[ARP_HDR_BYTES*8-1 -: 8];
    return b;
  endfunction

endpackage

// File: rtl/arp_tx_gmii_if.sv
// ---------------------------------------------------------------------------
// arp_tx_gmii_if
//   Request/stream bundle of the ARP transmitter.
//   start        request pulse into the transmitter
//   dst_ip       target IP, sampled when start is accepted
//   busy         transmitter occupied (start is ignored while high)
//   done         one-cycle pulse when busy falls
//   gmii_tx_data registered GMII byte
//   gmii_tx_en   registered GMII enable
//   dbg_state    current FSM state encoding, for observation only
//
//   Handshake: start acts as 'valid' and (!busy) as 'ready'. A request is
//   taken on the clock edge where start=1 and busy=0; dst_ip must be valid
//   on that edge. Requests while busy=1 are dropped, never queued. busy=0
//   coincides with done=1 for the cycle after a frame, so a start during
//   the done cycle is accepted.
// ---------------------------------------------------------------------------
interface arp_tx_gmii_if;
  logic        start;
  logic [31:0] dst_ip;
  logic        busy;
  logic        done;
  logic [7:0]  gmii_tx_data;
  logic        gmii_tx_en;
  logic [2:0]  dbg_state;

  modport master (
    output start, dst_ip,
    input  busy, done, gmii_tx_data, gmii_tx_en, dbg_state
  );

  modport slave (
    input  start, dst_ip,
    output busy, done, gmii_tx_data, gmii_tx_en, dbg_state
  );
endinterface

// File: rtl/arp_tx_gmii_crc32_d8.sv
// ---------------------------------------------------------------------------
// arp_tx_gmii_crc32_d8
//   Combinational next-state of the reflected IEEE CRC-32 for one byte,
//   bits consumed LSB first as they go onto the wire.
//   crc_in  [31:0] current CRC register
//   data    [7:0]  byte being transmitted
//   crc_out [31:0] CRC register after that byte
// ---------------------------------------------------------------------------
module arp_tx_gmii_crc32_d8
  import arp_tx_gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/arp_tx_gmii.sv
// ---------------------------------------------------------------------------
// arp_tx_gmii
//   Sends one broadcast ARP request per trigger as a GMII byte stream:
//   preamble/SFD, 60-byte body (Ethernet header, ARP, zero pad), CRC-32 FCS,
//   then an inter-frame gap before the next request is taken.
//
//   Ports
//     gmii_tx_clk  125 MHz transmit clock, the only clock
//     reset        asynchronous, active-high; aborts a frame immediately
//     bus          arp_tx_gmii_if.slave (start/dst_ip in, busy/done/GMII out)
//
//   Parameters
//     SRC_MAC, SRC_IP  sender addresses
//     IFG_CYCLES       idle line cycles between the last FCS byte and the
//                      first preamble byte of a back-to-back frame (>= 12)
//     AUTO_PERIOD      auto-trigger period in cycles (ARP_TX_AUTO_EN only)
//
//   Build option
//     ARP_TX_AUTO_EN   adds a free-running counter that raises an internal
//                      trigger every AUTO_PERIOD cycles, OR'd with start.
// ---------------------------------------------------------------------------
module arp_tx_gmii #(
  parameter logic [47:0] SRC_MAC    = 48'h000A3501FEC0,
  parameter logic [31:0] SRC_IP     = 32'hC0A80002,
  parameter int          IFG_CYCLES = 12
`ifdef ARP_TX_AUTO_EN
  ,
  parameter int          AUTO_PERIOD = 125_000_000
`endif
) (
  input  logic          gmii_tx_clk,
  input  logic          reset,
  arp_tx_gmii_if.slave  bus
);

  import arp_tx_gmii_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_BODY     = 3'd2,
    S_FCS      = 3'd3,
    S_IFG      = 3'd4
  } state_e;

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  localparam logic [5:0] PRE_LAST  = 6'(ETH_PREAMBLE_LEN - 1);
  localparam logic [5:0] BODY_LAST = 6'(ETH_MIN_BODY - 1);
  localparam logic [5:0] FCS_LAST  = 6'(ETH_FCS_LEN - 1);
  // The accept edge and the one-cycle start-up of the output register are
  // both idle on the line, so the IFG state itself is one cycle shorter
  // than the gap seen between frames; busy drops on its last cycle.
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 2);

  state_e             state, state_nx;
  logic [5:0]         cnt, cnt_nx;
  logic [IFG_W-1:0]   ifg_cnt, ifg_nx;
  logic [31:0]        dst_q;
  logic [31:0]        crc, crc_next;
  logic               crc_clr, crc_en;
  logic               accept;
  logic               trigger;
  logic [7:0]         body_byte;
  logic [31:0]        fcs;
  logic [7:0]         tx_data_q, tx_data_nx;
  logic               tx_en_q, tx_en_nx;
  logic               done_q, done_nx;

  // ---------------- trigger source ----------------
`ifdef ARP_TX_AUTO_EN
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_tick;

  // Free-running from reset; a tick that lands while busy is simply lost.
  assign auto_tick = (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));

  always_ff @(posedge gmii_tx_clk or posedge reset) begin
    if (reset)          auto_cnt <= '0;
    else if (auto_tick) auto_cnt <= '0;
    else                auto_cnt <= auto_cnt + 1'b1;
  end

  assign trigger = bus.start | auto_tick;
`else
  assign trigger = bus.start;
`endif

  // ---------------- datapath helpers ----------------
  assign body_byte = arp_body_byte(cnt, SRC_MAC, SRC_IP, dst_q);
  assign fcs       = ~crc;

  arp_tx_gmii_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (body_byte),
    .crc_out (crc_next)
  );

  // ---------------- FSM: next state and next outputs ----------------
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ifg_nx     = ifg_cnt;
    accept     = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    tx_en_nx   = 1'b0;
    tx_data_nx = 8'h00;
    done_nx    = 1'b0;

    case (state)
      S_IDLE: begin
        if (trigger) begin
          accept   = 1'b1;
          state_nx = S_PREAMBLE;
          cnt_nx   = '0;
        end
      end

      S_PREAMBLE: begin
        tx_en_nx   = 1'b1;
        tx_data_nx = (cnt == PRE_LAST) ? ETH_SFD : ETH_PREAMBLE;
        crc_clr    = 1'b1;
        if (cnt == PRE_LAST) begin
          state_nx = S_BODY;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + 6'd1;
        end
      end

      S_BODY: begin
        tx_en_nx   = 1'b1;
        tx_data_nx = body_byte;
        crc_en     = 1'b1;
        if (cnt == BODY_LAST) begin
          state_nx = S_FCS;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + 6'd1;
        end
      end

      S_FCS: begin
        tx_en_nx = 1'b1;
        // CRC is frozen here; FCS goes out least significant byte first.
        case (cnt[1:0])
          2'd0:    tx_data_nx = fcs[7:0];
          2'd1:    tx_data_nx = fcs[15:8];
          2'd2:    tx_data_nx = fcs[23:16];
          default: tx_data_nx = fcs[31:24];
        endcase
        if (cnt == FCS_LAST) begin
          state_nx = S_IFG;
          cnt_nx   = '0;
          ifg_nx   = '0;
        end else begin
          cnt_nx   = cnt + 6'd1;
        end
      end

      S_IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
          ifg_nx   = ifg_cnt + 1'b1;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge gmii_tx_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ifg_cnt   <= '0;
      dst_q     <= '0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ifg_cnt   <= ifg_nx;
      tx_data_q <= tx_data_nx;
      tx_en_q   <= tx_en_nx;
      done_q    <= done_nx;
      if (accept) dst_q <= bus.dst_ip;
    end
  end

  always_ff @(posedge gmii_tx_clk or posedge reset) begin
    if (reset)        crc <= CRC32_INIT;
    else if (crc_clr) crc <= CRC32_INIT;
    else if (crc_en)  crc <= crc_next;
  end

  // ---------------- outputs ----------------
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = done_q;
  assign bus.gmii_tx_data = tx_data_q;
  assign bus.gmii_tx_en   = tx_en_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_arp_tx_gmii.sv
// ---------------------------------------------------------------------------
// tb_arp_tx_gmii
//   Directed bench for arp_tx_gmii. A negedge monitor records the GMII
//   stream and event cycles; the initial block drives requests and checks
//   timing and frame contents against a locally built expected frame.
// ---------------------------------------------------------------------------
module tb_arp_tx_gmii;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  arp_tx_gmii_if bus ();

  arp_tx_gmii #(
`ifdef ARP_TX_AUTO_EN
    .AUTO_PERIOD (200),
`endif
    .IFG_CYCLES  (12)
  ) dut (
    .gmii_tx_clk (clk),
    .reset       (rst),
    .bus         (bus)
  );

  // ---------------- monitor ----------------
  logic [7:0] cap_q[$];
  int         rise_q[$];
  int         fall_q[$];
  int         done_q[$];
  logic       en_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.gmii_tx_en) cap_q.push_back(bus.gmii_tx_data);
    if (bus.gmii_tx_en && !en_prev) rise_q.push_back(cyc);
    if (!bus.gmii_tx_en && en_prev) fall_q.push_back(cyc);
    if (bus.done) done_q.push_back(cyc);
    en_prev = bus.gmii_tx_en;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ d[b]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Hand-written header for SRC_MAC 00:0A:35:01:FE:C0, SRC_IP 192.168.0.2.
  logic [7:0] hdr_tab [0:37] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h00, 8'h0A, 8'h35, 8'h01, 8'hFE, 8'hC0,
    8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
    8'h00, 8'h0A, 8'h35, 8'h01, 8'hFE, 8'hC0,
    8'hC0, 8'hA8, 8'h00, 8'h02,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  task automatic clear_mon();
    cap_q.delete();
    rise_q.delete();
    fall_q.delete();
    done_q.delete();
  endtask

  // Compares the oldest 72 captured bytes with the expected frame, then drops them.
  task automatic check_frame(input string tag, input logic [31:0] ip);
    logic [7:0]  exp_q[$];
    logic [31:0] c;
    logic [31:0] r;
    logic [31:0] rev;
    logic [63:0] pre;
    int          bad;
    int          n;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 38; i++) exp_q.push_back(hdr_tab[i]);
    exp_q.push_back(ip[31:24]);
    exp_q.push_back(ip[23:16]);
    exp_q.push_back(ip[15:8]);
    exp_q.push_back(ip[7:0]);
    for (int i = 0; i < 18; i++) exp_q.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 68; i++) c = crc_upd(c, exp_q[i]);
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);

    n = cap_q.size();
    check({tag, "_avail"}, 64'(n >= 72), 64'd1);
    bad = 0;
    pre = '0;
    r   = 32'hFFFFFFFF;
    for (int i = 0; i < 72; i++) begin
      if (i < n) begin
        if (cap_q[i] !== exp_q[i]) bad++;
        if (i < 8)  pre = {pre[55:0], cap_q[i]};
        if (i >= 8) r = crc_upd(r, cap_q[i]);
      end else begin
        bad++;
      end
    end
    for (int j = 0; j < 32; j++) rev[j] = r[31-j];
    check({tag, "_preamble"}, pre, 64'h55555555555555D5);
    check({tag, "_bad_bytes"}, 64'(bad), 64'd0);
    if (n >= 72) begin
      check({tag, "_tpa"}, {cap_q[46], cap_q[47], cap_q[48], cap_q[49]}, ip);
      check({tag, "_fcs"}, {cap_q[71], cap_q[70], cap_q[69], cap_q[68]}, c);
    end
    check({tag, "_residue"}, rev, 32'hC704DD7B);
    for (int i = 0; i < 72 && cap_q.size() > 0; i++) void'(cap_q.pop_front());
  endtask

  // ---------------- driver ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // start sampled by the DUT on edge n
  task automatic pulse_start(input int n, input logic [31:0] ip);
    wait_cyc(n - 1);
    bus.start  = 1'b1;
    bus.dst_ip = ip;
    wait_cyc(n);
    bus.start  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.dst_ip = 32'h0;
    wait_cyc(2);
    check("rst_tx_en", bus.gmii_tx_en, 0);
    check("rst_tx_data", bus.gmii_tx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    wait_cyc(3);
    rst = 1'b0;

`ifdef ARP_TX_AUTO_EN
    // Auto triggers with start held low: frames every 200 cycles.
    wait_cyc(800);
    check("auto_frames", 64'(rise_q.size() >= 3), 64'd1);
    if (rise_q.size() >= 3) begin
      check("auto_period0", 64'(rise_q[1] - rise_q[0]), 64'd200);
      check("auto_period1", 64'(rise_q[2] - rise_q[1]), 64'd200);
    end
    check_frame("auto_f0", 32'h0);
`else
    // 1: single frame accepted at edge 10
    pulse_start(10, 32'hC0A80003);
    check("t1_busy_accept", bus.busy, 1);
    check("t1_tx_en_pre", bus.gmii_tx_en, 0);
    wait_cyc(11);
    check("t1_tx_en_first", bus.gmii_tx_en, 1);
    check("t1_data_first", bus.gmii_tx_data, 8'h55);
    wait_cyc(92);
    check("t1_busy_before_done", bus.busy, 1);
    check("t1_done_early", bus.done, 0);
    wait_cyc(93);
    check("t1_busy_at_done", bus.busy, 0);
    check("t1_done_pulse", bus.done, 1);
    wait_cyc(94);
    check("t1_done_width", bus.done, 0);
    wait_cyc(100);
    check("t1_rise", 64'(rise_q.size() > 0 ? rise_q[0] : -1), 64'd11);
    check("t1_fall", 64'(fall_q.size() > 0 ? fall_q[0] : -1), 64'd83);
    check("t1_done_count", 64'(done_q.size()), 64'd1);
    check("t1_bytes", 64'(cap_q.size()), 64'd72);
    check_frame("t1", 32'hC0A80003);
    clear_mon();

    // 3: starts during BODY and IFG are ignored
    pulse_start(110, 32'h0A000001);
    pulse_start(140, 32'hFFFFFFFF);
    pulse_start(190, 32'h12345678);
    wait_cyc(230);
    check("t3_frames", 64'(rise_q.size()), 64'd1);
    check("t3_done_count", 64'(done_q.size()), 64'd1);
    check("t3_done_cyc", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd193);
    check_frame("t3", 32'h0A000001);
    clear_mon();

    // 4: start during the done cycle -> back-to-back frame
    pulse_start(240, 32'hC0A80064);
    wait_cyc(323);
    check("t4_done_seen", bus.done, 1);
    bus.start  = 1'b1;
    bus.dst_ip = 32'hAC100001;
    wait_cyc(324);
    bus.start  = 1'b0;
    check("t4_busy_again", bus.busy, 1);
    wait_cyc(415);
    check("t4_frames", 64'(rise_q.size()), 64'd2);
    check("t4_rise2", 64'(rise_q.size() > 1 ? rise_q[1] : -1), 64'd325);
    check("t4_gap", 64'((rise_q.size() > 1 && fall_q.size() > 0) ? rise_q[1] - fall_q[0] : -1), 64'd12);
    check("t4_done_count", 64'(done_q.size()), 64'd2);
    check("t4_done2", 64'(done_q.size() > 1 ? done_q[1] : -1), 64'd407);
    check("t4_bytes", 64'(cap_q.size()), 64'd144);
    check_frame("t4a", 32'hC0A80064);
    check_frame("t4b", 32'hAC100001);
    clear_mon();

    // 5: reset during body byte 30 aborts at once; next frame is clean
    pulse_start(440, 32'hC0A80005);
    wait_cyc(479);
    check("t5_mid_body", bus.gmii_tx_en, 1);
    rst = 1'b1;
    #1;
    check("t5_abort_tx_en", bus.gmii_tx_en, 0);
    check("t5_abort_busy", bus.busy, 0);
    check("t5_abort_done", bus.done, 0);
    wait_cyc(482);
    rst = 1'b0;
    wait_cyc(495);
    check("t5_no_done", 64'(done_q.size()), 64'd0);
    clear_mon();
    pulse_start(500, 32'hC0A80006);
    wait_cyc(600);
    check("t5_rise", 64'(rise_q.size() > 0 ? rise_q[0] : -1), 64'd501);
    check("t5_done", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd583);
    check_frame("t5", 32'hC0A80006);
    clear_mon();

    // 6: no auto trigger in this build; start low -> silence
    wait_cyc(1050);
    check("t6_no_frames", 64'(rise_q.size()), 64'd0);
    check("t6_idle_busy", bus.busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
